mesi_cpu_snoop_resp: RTL and testbench

Per-CPU coherence-bus responder for the MESI inter-cache controller: the CPU-side end of the coherence bus. It receives snoop/enable commands broadcast by the controller, looks up a small direct-mapped line-state array, and writes back Modified data over the main bus when required. It updates the line's MESI state and then acknowledges the command. One instance sits between the controller's per-CPU coherence port and that CPU's cache model.

---
 rtl/mesi_cpu_snoop_resp.sv | 252 +++++++++++++++++++++++++
 tb/tb_mesi_cpu_snoop_resp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_cpu_snoop_resp.sv
// mesi_cpu_snoop_resp: CPU-side coherence-bus responder for the MESI
// inter-cache controller. It looks up a small direct-mapped line-state
// array, writes back Modified data over the main bus when a snoop needs it,
// updates the line state and acknowledges the command.
// Optional feature macro: MESI_SNOOP_STATS_EN (snoop-hit / write-back counters).
module mesi_cpu_snoop_resp #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int LINES          = 4,
  parameter int LINE_IDX_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  output logic [DATA_WIDTH-1:0]     mbus_data_o,
  input  logic                      mbus_ack_i,
  input  logic                      lcl_wr_i,
  input  logic [ADDR_WIDTH-1:0]     lcl_addr_i,
  input  logic [DATA_WIDTH-1:0]     lcl_data_i,
  input  logic [1:0]                lcl_state_i,
  output logic                      lcl_rdy_o,
  output logic [2*LINES-1:0]        cache_state_o,
  output logic [15:0]               stat_hit_o,
  output logic [15:0]               stat_wb_o
);

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_NOP      = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CMD_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR  = MBUS_CMD_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, DECIDE, WB, ACK, HOLD} fsm_e;

  fsm_e                      fsm_q, fsm_d;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      cbus_ack_q, cbus_ack_d;
  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q, mbus_cmd_d;
  logic [ADDR_WIDTH-1:0]     mbus_addr_q, mbus_addr_d;
  logic [DATA_WIDTH-1:0]     mbus_data_q, mbus_data_d;
  logic [2*LINES-1:0]        cache_state_q, cache_state_d;

  logic [ADDR_WIDTH-1:0]     tag_q [LINES];
  logic [ADDR_WIDTH-1:0]     tag_d [LINES];
  logic [DATA_WIDTH-1:0]     data_q [LINES];
  logic [DATA_WIDTH-1:0]     data_d [LINES];
  logic [1:0]                state_q [LINES];
  logic [1:0]                state_d [LINES];

  logic [LINE_IDX_WIDTH-1:0] cmd_idx, lcl_idx;
  logic [1:0]                line_state;
  logic [ADDR_WIDTH-1:0]     line_tag;
  logic [DATA_WIDTH-1:0]     line_data;
  logic                      hit, snoop_hit, need_wb, upd_en;
  logic [ADDR_WIDTH-1:0]     upd_tag;
  logic [1:0]                upd_state;

  // Decode the captured command against the line it indexes; the line cannot
  // change outside IDLE, so the decision stays valid through WB.
  always_comb begin
    cmd_idx    = addr_q[LINE_IDX_WIDTH+1:2];
    lcl_idx    = lcl_addr_i[LINE_IDX_WIDTH+1:2];
    line_state = state_q[cmd_idx];
    line_tag   = tag_q[cmd_idx];
    line_data  = data_q[cmd_idx];
    hit        = (line_state != MESI_I) && (line_tag == addr_q);
    snoop_hit  = 1'b0;
    need_wb    = 1'b0;
    upd_en     = 1'b0;
    upd_tag    = line_tag;
    upd_state  = line_state;
    case (cmd_q)
      CMD_WR_SNOOP: begin
        if (hit) begin
          snoop_hit = 1'b1;
          upd_en    = 1'b1;
          upd_state = MESI_I;
          need_wb   = (line_state == MESI_M);
        end
      end
      CMD_RD_SNOOP: begin
        if (hit) begin
          snoop_hit = 1'b1;
          if (line_state == MESI_M || line_state == MESI_E) begin
            upd_en    = 1'b1;
            upd_state = MESI_S;
            need_wb   = (line_state == MESI_M);
          end
        end
      end
      CMD_EN_WR: begin
        upd_en    = 1'b1;
        upd_tag   = addr_q;
        upd_state = MESI_M;
      end
      CMD_EN_RD: begin
        upd_en    = 1'b1;
        upd_tag   = addr_q;
        upd_state = MESI_S;
      end
      default: ;
    endcase
  end

  // Next-state and registered-output computation for the responder FSM.
  always_comb begin
    fsm_d       = fsm_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    cbus_ack_d  = 1'b0;
    mbus_cmd_d  = mbus_cmd_q;
    mbus_addr_d = mbus_addr_q;
    mbus_data_d = mbus_data_q;
    tag_d       = tag_q;
    data_d      = data_q;
    state_d     = state_q;
    for (int n = 0; n < LINES; n++) begin
      cache_state_d[2*n +: 2] = state_q[n];
    end
    case (fsm_q)
      IDLE: begin
        if (lcl_wr_i) begin
          tag_d[lcl_idx]   = lcl_addr_i;
          data_d[lcl_idx]  = lcl_data_i;
          state_d[lcl_idx] = lcl_state_i;
        end
        if (cbus_cmd_i != CMD_NOP) begin
          cmd_d  = cbus_cmd_i;
          addr_d = cbus_addr_i;
          fsm_d  = DECIDE;
        end
      end
      DECIDE: begin
        if (need_wb) begin
          mbus_cmd_d  = MBUS_WR;
          mbus_addr_d = line_tag;
          mbus_data_d = line_data;
          fsm_d       = WB;
        end else begin
          if (upd_en) begin
            tag_d[cmd_idx]   = upd_tag;
            state_d[cmd_idx] = upd_state;
          end
          cbus_ack_d = 1'b1;
          fsm_d      = ACK;
        end
      end
      WB: begin
        if (mbus_ack_i) begin
          if (upd_en) begin
            tag_d[cmd_idx]   = upd_tag;
            state_d[cmd_idx] = upd_state;
          end
          mbus_cmd_d  = MBUS_NOP;
          mbus_addr_d = '0;
          mbus_data_d = '0;
          cbus_ack_d  = 1'b1;
          fsm_d       = ACK;
        end
      end
      ACK:     fsm_d = HOLD;
      HOLD:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Single register bank for FSM, captured command, bus outputs and line array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q         <= IDLE;
      cmd_q         <= CMD_NOP;
      addr_q        <= '0;
      cbus_ack_q    <= 1'b0;
      mbus_cmd_q    <= MBUS_NOP;
      mbus_addr_q   <= '0;
      mbus_data_q   <= '0;
      cache_state_q <= '0;
      for (int n = 0; n < LINES; n++) begin
        tag_q[n]   <= '0;
        data_q[n]  <= '0;
        state_q[n] <= MESI_I;
      end
    end else begin
      fsm_q         <= fsm_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      cbus_ack_q    <= cbus_ack_d;
      mbus_cmd_q    <= mbus_cmd_d;
      mbus_addr_q   <= mbus_addr_d;
      mbus_data_q   <= mbus_data_d;
      cache_state_q <= cache_state_d;
      tag_q         <= tag_d;
      data_q        <= data_d;
      state_q       <= state_d;
    end
  end

  assign cbus_ack_o    = cbus_ack_q;
  assign mbus_cmd_o    = mbus_cmd_q;
  assign mbus_addr_o   = mbus_addr_q;
  assign mbus_data_o   = mbus_data_q;
  assign lcl_rdy_o     = (fsm_q == IDLE);
  assign cache_state_o = cache_state_q;

`ifdef MESI_SNOOP_STATS_EN
  logic [15:0] stat_hit_q, stat_hit_d, stat_wb_q, stat_wb_d;
  logic        hit_evt, wb_evt;

  // Saturating counters: a hit counts when its command is acked, a write-back when it completes.
  always_comb begin
    wb_evt     = (fsm_q == WB) && mbus_ack_i;
    hit_evt    = snoop_hit && (((fsm_q == DECIDE) && !need_wb) || wb_evt);
    stat_hit_d = stat_hit_q;
    stat_wb_d  = stat_wb_q;
    if (hit_evt && stat_hit_q != 16'hFFFF) stat_hit_d = stat_hit_q + 16'd1;
    if (wb_evt && stat_wb_q != 16'hFFFF)   stat_wb_d  = stat_wb_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hit_q <= '0;
      stat_wb_q  <= '0;
    end else begin
      stat_hit_q <= stat_hit_d;
      stat_wb_q  <= stat_wb_d;
    end
  end

  assign stat_hit_o = stat_hit_q;
  assign stat_wb_o  = stat_wb_q;
`else
  assign stat_hit_o = '0;
  assign stat_wb_o  = '0;
`endif

endmodule

// File: tb/tb_mesi_cpu_snoop_resp.sv
// Testbench for mesi_cpu_snoop_resp: table of directed coherence commands
// with hand-computed ack timing, write-back contents and line states, plus
// hand-written sequences for reset during write-back and counter behaviour.
module tb_mesi_cpu_snoop_resp;

  logic        clk;
  logic        rst;
  logic [2:0]  cbus_cmd_i;
  logic [31:0] cbus_addr_i;
  logic        cbus_ack_o;
  logic [2:0]  mbus_cmd_o;
  logic [31:0] mbus_addr_o;
  logic [31:0] mbus_data_o;
  logic        mbus_ack_i;
  logic        lcl_wr_i;
  logic [31:0] lcl_addr_i;
  logic [31:0] lcl_data_i;
  logic [1:0]  lcl_state_i;
  logic        lcl_rdy_o;
  logic [7:0]  cache_state_o;
  logic [15:0] stat_hit_o;
  logic [15:0] stat_wb_o;

`ifdef MESI_SNOOP_STATS_EN
  localparam bit STATS = 1'b1;
  localparam int SAT_LOOPS = 70000;
  localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
  localparam bit STATS = 1'b0;
  localparam int SAT_LOOPS = 5;
  localparam logic [15:0] SAT_EXP = 16'h0000;
`endif

  mesi_cpu_snoop_resp dut (
    .clk           (clk),
    .rst           (rst),
    .cbus_cmd_i    (cbus_cmd_i),
    .cbus_addr_i   (cbus_addr_i),
    .cbus_ack_o    (cbus_ack_o),
    .mbus_cmd_o    (mbus_cmd_o),
    .mbus_addr_o   (mbus_addr_o),
    .mbus_data_o   (mbus_data_o),
    .mbus_ack_i    (mbus_ack_i),
    .lcl_wr_i      (lcl_wr_i),
    .lcl_addr_i    (lcl_addr_i),
    .lcl_data_i    (lcl_data_i),
    .lcl_state_i   (lcl_state_i),
    .lcl_rdy_o     (lcl_rdy_o),
    .cache_state_o (cache_state_o),
    .stat_hit_o    (stat_hit_o),
    .stat_wb_o     (stat_wb_o)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          wrMode;      // 0 none, 1 write the cycle before, 2 write in the capture cycle
    logic [31:0] wrAddr;
    logic [31:0] wrData;
    logic [1:0]  wrState;
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic        preAck;      // mbus_ack_i high during capture and DECIDE cycles
    int          mbAckAfter;  // mbus_ack_i raised in this WB cycle (1-based)
    int          expAck;
    logic        expWb;
    logic [31:0] expWbAddr;
    logic [31:0] expWbData;
    logic [7:0]  expCache;
    int          expHits;
    int          expWbs;
  } vec_t;

  vec_t vecs [14];

  int checkCount = 0;
  int missCount  = 0;

  int          ackCycle, ackCount, wbFirst, wbCycles;
  logic [31:0] wbAddr, wbData;
  logic        wbUnstable, rdyAtDecide;
  logic [2:0]  mbusAtAck;
  logic [7:0]  cacheAfter;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic lclWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    checkOutput("lcl_rdy before write", 32'(lcl_rdy_o), 32'd1);
    lcl_wr_i    = 1'b1;
    lcl_addr_i  = a;
    lcl_data_i  = d;
    lcl_state_i = s;
    @(negedge clk);
    lcl_wr_i = 1'b0;
  endtask

  // Drives one command starting in the current (IDLE) cycle and watches it to HOLD, then steps to IDLE.
  task automatic applyStimulus(input vec_t v);
    cbus_cmd_i  = v.cmd;
    cbus_addr_i = v.addr;
    mbus_ack_i  = v.preAck;
    if (v.wrMode == 2) begin
      lcl_wr_i    = 1'b1;
      lcl_addr_i  = v.wrAddr;
      lcl_data_i  = v.wrData;
      lcl_state_i = v.wrState;
    end
    ackCycle = 0; ackCount = 0; wbFirst = 0; wbCycles = 0;
    wbUnstable = 1'b0; rdyAtDecide = 1'b1; mbusAtAck = 3'h7; cacheAfter = 8'h00;
    wbAddr = '0; wbData = '0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        rdyAtDecide = lcl_rdy_o;
        cbus_cmd_i  = 3'd0;
        cbus_addr_i = '0;
        lcl_wr_i    = 1'b0;
      end
      if (mbus_cmd_o == 3'd1) begin
        wbCycles++;
        if (wbFirst == 0) begin
          wbFirst = cyc;
          wbAddr  = mbus_addr_o;
          wbData  = mbus_data_o;
        end else if (mbus_addr_o !== wbAddr || mbus_data_o !== wbData) begin
          wbUnstable = 1'b1;
        end
      end
      if (cyc <= 1) mbus_ack_i = v.preAck;
      else          mbus_ack_i = (mbus_cmd_o == 3'd1) && (wbCycles == v.mbAckAfter);
      if (cbus_ack_o) begin
        ackCount++;
        if (ackCycle == 0) begin
          ackCycle  = cyc;
          mbusAtAck = mbus_cmd_o;
        end
      end
      if (ackCycle != 0 && cyc == ackCycle + 1) begin
        cacheAfter = cache_state_o;
        break;
      end
    end
    mbus_ack_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h0,  32'h0,        2'd0, 3'd2, 32'h10, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h00, 0, 0};
    vecs[1]  = '{1, 32'h14, 32'h1111,     2'd2, 3'd2, 32'h14, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h04, 1, 0};
    vecs[2]  = '{1, 32'h08, 32'hDEADBEEF, 2'd3, 3'd1, 32'h08, 1'b0, 3, 5, 1'b1, 32'h08, 32'hDEADBEEF, 8'h04, 2, 1};
    vecs[3]  = '{0, 32'h0,  32'h0,        2'd0, 3'd3, 32'h0C, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'hC4, 2, 1};
    vecs[4]  = '{0, 32'h0,  32'h0,        2'd0, 3'd2, 32'h1C, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'hC4, 2, 1};
    vecs[5]  = '{0, 32'h0,  32'h0,        2'd0, 3'd2, 32'h0C, 1'b0, 1, 3, 1'b1, 32'h0C, 32'h0,        8'h44, 3, 2};
    vecs[6]  = '{0, 32'h0,  32'h0,        2'd0, 3'd4, 32'h20, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h45, 3, 2};
    vecs[7]  = '{0, 32'h0,  32'h0,        2'd0, 3'd5, 32'h20, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h45, 3, 2};
    vecs[8]  = '{2, 32'h30, 32'h55AA,     2'd2, 3'd1, 32'h30, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h44, 4, 2};
    vecs[9]  = '{0, 32'h0,  32'h0,        2'd0, 3'd7, 32'h14, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h44, 4, 2};
    vecs[10] = '{0, 32'h0,  32'h0,        2'd0, 3'd1, 32'h14, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h40, 5, 2};
    vecs[11] = '{0, 32'h0,  32'h0,        2'd0, 3'd2, 32'h0C, 1'b0, 0, 2, 1'b0, 32'h0,  32'h0,        8'h40, 6, 2};
    vecs[12] = '{1, 32'h04, 32'hCAFEF00D, 2'd3, 3'd2, 32'h04, 1'b0, 2, 4, 1'b1, 32'h04, 32'hCAFEF00D, 8'h44, 7, 3};
    vecs[13] = '{1, 32'h18, 32'h12345678, 2'd3, 3'd1, 32'h18, 1'b1, 2, 4, 1'b1, 32'h18, 32'h12345678, 8'h44, 8, 4};

    rst = 1'b1; cbus_cmd_i = '0; cbus_addr_i = '0; mbus_ack_i = 1'b0;
    lcl_wr_i = 1'b0; lcl_addr_i = '0; lcl_data_i = '0; lcl_state_i = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset cbus_ack", 32'(cbus_ack_o), 32'd0);
    checkOutput("reset mbus_cmd", 32'(mbus_cmd_o), 32'd0);
    checkOutput("reset mbus_addr", mbus_addr_o, 32'd0);
    checkOutput("reset mbus_data", mbus_data_o, 32'd0);
    checkOutput("reset lcl_rdy", 32'(lcl_rdy_o), 32'd1);
    checkOutput("reset cache_state", 32'(cache_state_o), 32'd0);
    checkOutput("reset stat_hit", 32'(stat_hit_o), 32'd0);
    checkOutput("reset stat_wb", 32'(stat_wb_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wrMode == 1) lclWrite(vecs[i].wrAddr, vecs[i].wrData, vecs[i].wrState);
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d ack_cycle", i), 32'(ackCycle), 32'(vecs[i].expAck));
      checkOutput($sformatf("v%0d ack_pulses", i), 32'(ackCount), 32'd1);
      checkOutput($sformatf("v%0d rdy_in_decide", i), 32'(rdyAtDecide), 32'd0);
      checkOutput($sformatf("v%0d wb_first_cycle", i), 32'(wbFirst), vecs[i].expWb ? 32'd2 : 32'd0);
      if (vecs[i].expWb) begin
        checkOutput($sformatf("v%0d wb_addr", i), wbAddr, vecs[i].expWbAddr);
        checkOutput($sformatf("v%0d wb_data", i), wbData, vecs[i].expWbData);
        checkOutput($sformatf("v%0d wb_stable", i), 32'(wbUnstable), 32'd0);
        checkOutput($sformatf("v%0d mbus_at_ack", i), 32'(mbusAtAck), 32'd0);
      end
      checkOutput($sformatf("v%0d cache_state", i), 32'(cacheAfter), 32'(vecs[i].expCache));
      checkOutput($sformatf("v%0d stat_hit", i), 32'(stat_hit_o), STATS ? 32'(vecs[i].expHits) : 32'd0);
      checkOutput($sformatf("v%0d stat_wb", i), 32'(stat_wb_o), STATS ? 32'(vecs[i].expWbs) : 32'd0);
    end

    // Reset asserted while a write-back is waiting for mbus_ack_i.
    begin
      logic ackSeen;
      lclWrite(32'h28, 32'hA5A5A5A5, 2'd3);
      cbus_cmd_i  = 3'd1;
      cbus_addr_i = 32'h28;
      @(negedge clk);
      cbus_cmd_i  = 3'd0;
      cbus_addr_i = '0;
      repeat (2) @(negedge clk);
      checkOutput("rstwb mbus_cmd before reset", 32'(mbus_cmd_o), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("rstwb mbus_cmd", 32'(mbus_cmd_o), 32'd0);
      checkOutput("rstwb mbus_addr", mbus_addr_o, 32'd0);
      checkOutput("rstwb mbus_data", mbus_data_o, 32'd0);
      checkOutput("rstwb cbus_ack", 32'(cbus_ack_o), 32'd0);
      checkOutput("rstwb lcl_rdy", 32'(lcl_rdy_o), 32'd1);
      checkOutput("rstwb cache_state", 32'(cache_state_o), 32'd0);
      checkOutput("rstwb stat_wb", 32'(stat_wb_o), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      ackSeen = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (cbus_ack_o || mbus_cmd_o != 3'd0) ackSeen = 1'b1;
      end
      checkOutput("rstwb no ack after release", 32'(ackSeen), 32'd0);
      checkOutput("rstwb lines invalid", 32'(cache_state_o), 32'd0);
    end

    // Repeated hitting RD_SNOOPs on a Shared line: counter saturates (or stays 0 without stats).
    lclWrite(32'h14, 32'h0, 2'd1);
    for (int i = 0; i < SAT_LOOPS; i++) begin
      @(negedge clk);
      cbus_cmd_i  = 3'd2;
      cbus_addr_i = 32'h14;
      @(negedge clk);
      cbus_cmd_i  = 3'd0;
      cbus_addr_i = '0;
      repeat (2) @(negedge clk);
    end
    checkOutput("stat_hit after hit loop", 32'(stat_hit_o), 32'(SAT_EXP));
    checkOutput("line 1 still S after hit loop", 32'(cache_state_o), 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
